attn_reader_stream: RTL and testbench

ATTN_READER_STREAM -- requirements
Module: attn_reader_stream

---
 rtl/attn_reader_stream.sv | 84 ++++++++
 tb/tb_attn_reader_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/attn_reader_stream.sv
// attn_reader_stream: streams score/value beats and accumulates score*value per lane, then holds the result.
// Define ATTN_READER_SAT_EN to clamp each lane to the OUT_W range instead of wrapping.
module attn_reader_stream #(
    parameter int SEQ_MAX  = 8,
    parameter int HEAD_DIM = 4,
    parameter int DW       = 8,
    parameter int FRAC_W   = 8,
    parameter int OUT_W    = DW + FRAC_W + 1 + $clog2(SEQ_MAX)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(SEQ_MAX):0]    seq_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FRAC_W-1:0]           in_score,
    input  logic [HEAD_DIM*DW-1:0]      in_v,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [HEAD_DIM*OUT_W-1:0]   out_vec,
    output logic                        busy,
    output logic                        err
);
    localparam int ACC_W = DW + FRAC_W + 1 + $clog2(SEQ_MAX);
    localparam int PW    = DW + FRAC_W + 1;
    localparam int CW    = $clog2(SEQ_MAX) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state;
    logic [CW-1:0]           len;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc  [HEAD_DIM];
    logic signed [PW-1:0]    prod [HEAD_DIM];

    assign in_ready  = state == ACCUM;
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            for (int h = 0; h < HEAD_DIM; h++) acc[h] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (seq_len != '0 && seq_len <= CW'(SEQ_MAX)) begin
                        len   <= seq_len;
                        cnt   <= '0;
                        state <= ACCUM;
                        for (int h = 0; h < HEAD_DIM; h++) acc[h] <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end
                ACCUM: if (in_valid) begin
                    cnt <= cnt + CW'(1);
                    for (int h = 0; h < HEAD_DIM; h++) acc[h] <= acc[h] + ACC_W'(prod[h]);
                    if (cnt == len - CW'(1)) state <= HOLD;
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < HEAD_DIM; g++) begin : g_lane
        // score is unsigned, so a zero MSB is prepended before the signed multiply
        assign prod[g] = PW'($signed({1'b0, in_score})) * PW'($signed(in_v[g*DW +: DW]));
`ifdef ATTN_READER_SAT_EN
        logic s;
        logic fits;
        assign s    = acc[g][ACC_W-1];
        assign fits = acc[g][ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){s}};
        assign out_vec[g*OUT_W +: OUT_W] = fits ? acc[g][OUT_W-1:0] : {s, {(OUT_W-1){~s}}};
`else
        assign out_vec[g*OUT_W +: OUT_W] = acc[g][OUT_W-1:0];
`endif
    end
endmodule

// File: tb/tb_attn_reader_stream.sv
// tb_attn_reader_stream: scoreboard bench driving an OUT_W=11 and an OUT_W=8 instance with shared stimulus.
module tb_attn_reader_stream;
    typedef struct {
        int l0;
        int l1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  seq_len = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_score = '0;
    logic [7:0]  in_v = '0;
    logic        out_ready = 1'b0;
    logic        in_ready_a, out_valid_a, busy_a, err_a;
    logic        in_ready_b, out_valid_b, busy_b, err_b;
    logic [21:0] out_vec_a;
    logic [15:0] out_vec_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    attn_reader_stream #(.SEQ_MAX(4), .HEAD_DIM(2), .DW(4), .FRAC_W(4), .OUT_W(11)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_score(in_score), .in_v(in_v),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_vec(out_vec_a),
        .busy(busy_a), .err(err_a)
    );

    attn_reader_stream #(.SEQ_MAX(4), .HEAD_DIM(2), .DW(4), .FRAC_W(4), .OUT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_score(in_score), .in_v(in_v),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_vec(out_vec_b),
        .busy(busy_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, $signed(got), $signed(want));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a0, input int a1, input int b0, input int b1);
        q_a.push_back('{a0, a1});
        q_b.push_back('{b0, b1});
    endtask

    task automatic beat(input logic [3:0] sc, input int v0, input int v1, input int gap);
        in_valid = 1'b1;
        in_score = sc;
        in_v     = {4'(v1), 4'(v0)};
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic launch(input logic [2:0] len);
        start   = 1'b1;
        seq_len = len;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy_a}, 32'd1);
    endtask

    task automatic drain(input int stall);
        chk("valid_after_last_beat", {31'b0, out_valid_a & out_valid_b}, 32'd1);
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_handshake", {30'b0, busy_a, out_valid_a}, 32'd0);
    endtask

    // Scoreboard monitor: pops on handshake, checks stability against the head while stalled.
    always @(negedge clk) begin
        if (out_valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_a lanes %0d %0d", $signed(out_vec_a[10:0]), $signed(out_vec_a[21:11]));
            end else begin
                chk(out_ready ? "out_a_lane0" : "hold_a_lane0", 32'($signed(out_vec_a[10:0])), q_a[0].l0);
                chk(out_ready ? "out_a_lane1" : "hold_a_lane1", 32'($signed(out_vec_a[21:11])), q_a[0].l1);
                if (out_ready) void'(q_a.pop_front());
            end
        end
        if (out_valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_b lanes %0d %0d", $signed(out_vec_b[7:0]), $signed(out_vec_b[15:8]));
            end else begin
                chk(out_ready ? "out_b_lane0" : "hold_b_lane0", 32'($signed(out_vec_b[7:0])), q_b[0].l0);
                chk(out_ready ? "out_b_lane1" : "hold_b_lane1", 32'($signed(out_vec_b[15:8])), q_b[0].l1);
                if (out_ready) void'(q_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset_outputs_a", {27'b0, in_ready_a, out_valid_a, busy_a, err_a, |out_vec_a}, 32'd0);
        chk("reset_outputs_b", {27'b0, in_ready_b, out_valid_b, busy_b, err_b, |out_vec_b}, 32'd0);
        @(posedge clk);
        #1;
        // basic run, start on the first edge after reset release
        rst_n = 1'b1;
        push(0, 8, 0, 8);
        launch(3);
        chk("in_ready_accum", {31'b0, in_ready_a}, 32'd1);
        beat(8, 2, -3, 0);
        beat(4, 4, 1, 0);
        beat(4, -8, 7, 0);
        drain(0);
        // stalls on both sides
        push(0, 8, 0, 8);
        launch(3);
        beat(8, 2, -3, 2);
        chk("cnt_stall_no_valid", {31'b0, out_valid_a}, 32'd0);
        beat(4, 4, 1, 2);
        beat(4, -8, 7, 0);
        drain(3);
        // saturation vs wrap on the narrow instance
`ifdef ATTN_READER_SAT_EN
        push(-480, -480, -128, -128);
`else
        push(-480, -480, 32, 32);
`endif
        launch(4);
        for (int i = 0; i < 4; i++) beat(15, -8, -8, 0);
        drain(1);
        // rejected starts
        start   = 1'b1;
        seq_len = 3'd0;
        tick();
        chk("err_len0", {29'b0, err_a, busy_a, in_ready_a}, 32'd4);
        seq_len = 3'd5;
        tick();
        chk("err_len5", {29'b0, err_a, busy_a, in_ready_a}, 32'd4);
        start = 1'b0;
        tick();
        chk("err_drops", {29'b0, err_a, busy_a, in_ready_a}, 32'd0);
        // reset mid-run
        launch(3);
        beat(15, 7, 7, 0);
        beat(15, 7, 7, 0);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_a", {27'b0, in_ready_a, out_valid_a, busy_a, err_a, |out_vec_a}, 32'd0);
        chk("midrun_reset_b", {27'b0, in_ready_b, out_valid_b, busy_b, err_b, |out_vec_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        push(15, 15, 15, 15);
        launch(1);
        beat(15, 1, 1, 0);
        drain(0);
        // start coinciding with HOLD handshake is ignored, next cycle honoured
        push(3, -2, 3, -2);
        launch(1);
        beat(1, 3, -2, 0);
        chk("hold_valid", {31'b0, out_valid_a}, 32'd1);
        out_ready = 1'b1;
        start     = 1'b1;
        seq_len   = 3'd1;
        tick();
        out_ready = 1'b0;
        chk("hold_start_ignored", {30'b0, err_a, busy_a}, 32'd0);
        push(-2, 10, -2, 10);
        tick();
        start = 1'b0;
        chk("start_after_hold", {30'b0, err_a, busy_a}, 32'd1);
        beat(2, -1, 5, 0);
        drain(0);
        tick();
        chk("queue_a_empty", q_a.size(), 32'd0);
        chk("queue_b_empty", q_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
